// File: rtl/tty_ctrl.sv
// tty_ctrl: console sequencer writing char/attr cells into text video RAM.
// Optional TTY_TAB_EN enables hardware tab stops every 8 columns.
module tty_ctrl #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 25,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        put_valid,
   output logic        put_ready,
   input  logic [7:0]  put_char,
   input  logic [7:0]  put_attr,
   output logic [11:0] m_address,
   output logic [7:0]  m_wdata,
   output logic        m_we,
   input  logic [7:0]  m_rdata,
   output logic [10:0] cursor,
   output logic        busy
);

   localparam int          CELLS    = COLS * ROWS;
   localparam logic [10:0] C_COLS   = 11'(COLS);
   localparam logic [10:0] C_LAST   = 11'((ROWS - 1) * COLS);
   localparam logic [10:0] C_END    = 11'(CELLS - 1);
   localparam logic [11:0] ROWB     = 12'(2 * COLS);
   localparam logic [11:0] SCR_END  = 12'(2 * COLS * (ROWS - 1));
   localparam logic [11:0] BYTE_END = 12'(2 * CELLS - 1);

   typedef enum logic [2:0] {
      IDLE,
      PUT_C,
      PUT_A,
      SCR_RD,
      SCR_WR,
      FILL
   } state_e;

   state_e      state_q;
   logic [10:0] cur_q;
   logic [10:0] col_q;
   logic [11:0] ptr_q;
   logic [7:0]  attr_q;
   logic [11:0] addr_q;
   logic [7:0]  wdata_q;
   logic        we_q;
   logic        ready_q;

   logic [11:0] ptr_d;
   logic        is_cr;
   logic        is_bs;
   logic        is_lf;
   logic        is_ff;
`ifdef TTY_TAB_EN
   logic        is_tab;
   logic [10:0] tab_col_d;
`endif

   // Control-code decode and shared increment; ptr is dst in scroll, idx in fill.
   always_comb begin
      ptr_d = ptr_q + 12'd1;
      is_cr = (put_char == 8'h0D);
      is_bs = (put_char == 8'h08);
      is_lf = (put_char == 8'h0A);
      is_ff = (put_char == 8'h0C);
`ifdef TTY_TAB_EN
      is_tab    = (put_char == 8'h09);
      tab_col_d = (col_q | 11'd7) + 11'd1;
      if (tab_col_d > C_COLS - 11'd1) begin
         tab_col_d = C_COLS - 11'd1;
      end
`endif
   end

   // Sequencer with registered RAM strobes; source address is dst + one row.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cur_q   <= '0;
         col_q   <= '0;
         ptr_q   <= '0;
         attr_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (put_valid) begin
                  attr_q <= put_attr;
                  unique case (1'b1)
                     is_cr: begin
                        cur_q <= cur_q - col_q;
                        col_q <= '0;
                     end
                     is_bs: begin
                        if (cur_q != '0) begin
                           cur_q <= cur_q - 11'd1;
                           col_q <= (col_q == '0) ? C_COLS - 11'd1
                                                  : col_q - 11'd1;
                        end
                     end
                     is_lf: begin
                        if (cur_q < C_LAST) begin
                           cur_q <= cur_q + C_COLS;
                        end else begin
                           state_q <= SCR_RD;
                           ptr_q   <= '0;
                           addr_q  <= ROWB;
                           ready_q <= 1'b0;
                        end
                     end
                     is_ff: begin
                        cur_q   <= '0;
                        col_q   <= '0;
                        ptr_q   <= '0;
                        addr_q  <= '0;
                        wdata_q <= BLANK;
                        we_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= FILL;
                     end
`ifdef TTY_TAB_EN
                     is_tab: begin
                        cur_q <= cur_q - col_q + tab_col_d;
                        col_q <= tab_col_d;
                     end
`endif
                     default: begin
                        addr_q  <= {cur_q, 1'b0};
                        wdata_q <= put_char;
                        we_q    <= 1'b1;
                        ready_q <= 1'b0;
                        state_q <= PUT_C;
                     end
                  endcase
               end
            end
            PUT_C: begin
               addr_q  <= {cur_q, 1'b1};
               wdata_q <= attr_q;
               we_q    <= 1'b1;
               state_q <= PUT_A;
            end
            PUT_A: begin
               we_q <= 1'b0;
               if (cur_q == C_END) begin
                  cur_q   <= C_LAST;
                  col_q   <= '0;
                  ptr_q   <= '0;
                  addr_q  <= ROWB;
                  state_q <= SCR_RD;
               end else begin
                  cur_q   <= cur_q + 11'd1;
                  col_q   <= (col_q == C_COLS - 11'd1) ? '0
                                                       : col_q + 11'd1;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end
            end
            SCR_RD: begin
               addr_q  <= ptr_q;
               we_q    <= 1'b1;
               state_q <= SCR_WR;
            end
            SCR_WR: begin
               ptr_q  <= ptr_d;
               if (ptr_d == SCR_END) begin
                  addr_q  <= ptr_d;
                  wdata_q <= BLANK;
                  we_q    <= 1'b1;
                  state_q <= FILL;
               end else begin
                  addr_q  <= ptr_d + ROWB;
                  we_q    <= 1'b0;
                  state_q <= SCR_RD;
               end
            end
            FILL: begin
               if (ptr_q == BYTE_END) begin
                  we_q    <= 1'b0;
                  ready_q <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  ptr_q   <= ptr_d;
                  addr_q  <= ptr_d;
                  wdata_q <= ptr_d[0] ? attr_q : BLANK;
                  we_q    <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               we_q    <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Copy path forwards the synchronous read data straight to the write port.
   assign m_wdata   = (state_q == SCR_WR) ? m_rdata : wdata_q;
   assign m_address = addr_q;
   assign m_we      = we_q;
   assign put_ready = ready_q;
   assign busy      = ~ready_q;
   assign cursor    = cur_q;

endmodule

// File: tb/tb_tty_ctrl.sv
// tb_tty_ctrl: directed checks of tty_ctrl against a behavioural video RAM.
// Covers print, CR/LF/BS, wrap scroll, LF scroll, clear, reset abort, tab.
module tb_tty_ctrl;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        put_valid;
   logic        put_ready;
   logic [7:0]  put_char;
   logic [7:0]  put_attr;
   logic [11:0] m_address;
   logic [7:0]  m_wdata;
   logic        m_we;
   logic [7:0]  m_rdata;
   logic [10:0] cursor;
   logic        busy;

   logic [7:0] mem  [0:4095];
   logic [7:0] snap [0:4095];
   bit         inited = 1'b0;
   int         we_cnt = 0;
   int         bad_addr = 0;
   int         n_chk = 0;
   int         n_err = 0;

   tty_ctrl dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .put_valid (put_valid),
      .put_ready (put_ready),
      .put_char  (put_char),
      .put_attr  (put_attr),
      .m_address (m_address),
      .m_wdata   (m_wdata),
      .m_we      (m_we),
      .m_rdata   (m_rdata),
      .cursor    (cursor),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Synchronous video RAM preloaded with a recognisable pattern.
   always @(posedge clock) begin
      if (!inited) begin
         for (int i = 0; i < 4096; i++) mem[i] <= 8'(i) ^ 8'hA5;
         inited <= 1'b1;
      end else begin
         if (m_we) begin
            mem[m_address] <= m_wdata;
            we_cnt++;
            if (m_address >= 12'd4000) bad_addr++;
         end
         m_rdata <= mem[m_address];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic put(input logic [7:0] c, input logic [7:0] a);
      int n = 0;
      while (!put_ready && n < 20000) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20000) check("put_timeout", 32'(put_ready), 1);
      put_valid = 1'b1;
      put_char  = c;
      put_attr  = a;
      @(posedge clock);
      #1 put_valid = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 0;
      @(negedge clock);
      while (!put_ready && cyc < 20000) begin
         cyc++;
         @(negedge clock);
      end
   endtask

   task automatic putw(input logic [7:0] c, input logic [7:0] a);
      int cyc;
      put(c, a);
      wait_ready(cyc);
   endtask

   initial begin
      int cyc;
      int w0;
      int bad;
      reset_n   = 1'b0;
      put_valid = 1'b0;
      put_char  = 8'h00;
      put_attr  = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_cursor", 32'(cursor), 0);
      check("rst_ready", 32'(put_ready), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_we", 32'(m_we), 0);
      check("rst_addr", 32'(m_address), 0);
      check("rst_wdata", 32'(m_wdata), 0);
      reset_n = 1'b1;
      @(negedge clock);

      w0 = we_cnt;
      put(8'h41, 8'h17);
      @(negedge clock);
      check("A_we0", 32'(m_we), 1);
      check("A_addr0", 32'(m_address), 0);
      check("A_data0", 32'(m_wdata), 8'h41);
      check("A_busy0", 32'(busy), 1);
      @(negedge clock);
      check("A_addr1", 32'(m_address), 1);
      check("A_data1", 32'(m_wdata), 8'h17);
      check("A_ready1", 32'(put_ready), 0);
      @(negedge clock);
      check("A_ready2", 32'(put_ready), 1);
      check("A_cursor", 32'(cursor), 1);
      check("A_mem0", 32'(mem[0]), 8'h41);
      check("A_mem1", 32'(mem[1]), 8'h17);
      check("A_wecnt", 32'(we_cnt - w0), 2);

      putw(8'h0D, 8'h07);
      putw(8'h0A, 8'h07);
      for (int i = 0; i < 5; i++) putw(8'h61 + 8'(i), 8'h07);
      check("cur85", 32'(cursor), 85);
      w0 = we_cnt;
      put(8'h0D, 8'h07);
      @(negedge clock);
      check("cr_cursor", 32'(cursor), 80);
      check("cr_ready", 32'(put_ready), 1);
      put(8'h0A, 8'h07);
      @(negedge clock);
      check("lf_cursor", 32'(cursor), 160);
      check("crlf_nowe", 32'(we_cnt - w0), 0);

      for (int i = 0; i < 22; i++) putw(8'h0A, 8'h07);
      check("lf_row24", 32'(cursor), 1920);
      for (int i = 0; i < 79; i++) putw(8'h30 + 8'(i), 8'h07);
      check("cur1999", 32'(cursor), 1999);
      for (int i = 0; i < 4096; i++) snap[i] = mem[i];
      w0 = we_cnt;
      put(8'h42, 8'h07);
      wait_ready(cyc);
      check("wrap_busy", 32'(cyc), 7842);
      check("wrap_cursor", 32'(cursor), 1920);
      check("wrap_wecnt", 32'(we_cnt - w0), 4002);
      bad = 0;
      for (int i = 0; i < 3838; i++) if (mem[i] !== snap[i + 160]) bad++;
      check("wrap_copy", 32'(bad), 0);
      check("wrap_m0", 32'(mem[0]), 8'h61);
      check("wrap_m1", 32'(mem[1]), 8'h07);
      check("wrap_m8", 32'(mem[8]), 8'h65);
      check("wrap_m3680", 32'(mem[3680]), 8'h30);
      check("wrap_m3838", 32'(mem[3838]), 8'h42);
      check("wrap_m3839", 32'(mem[3839]), 8'h07);
      bad = 0;
      for (int i = 3840; i < 4000; i++)
         if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h07)) bad++;
      check("wrap_fill", 32'(bad), 0);

      w0 = we_cnt;
      put(8'h0C, 8'h1F);
      wait_ready(cyc);
      check("ff_busy", 32'(cyc), 4000);
      check("ff_cursor", 32'(cursor), 0);
      check("ff_wecnt", 32'(we_cnt - w0), 4000);
      bad = 0;
      for (int i = 0; i < 4000; i++)
         if (mem[i] !== ((i % 2 == 0) ? 8'h20 : 8'h1F)) bad++;
      check("ff_image", 32'(bad), 0);

      put(8'h08, 8'h07);
      @(negedge clock);
      check("bs0_cursor", 32'(cursor), 0);
      check("bs0_ready", 32'(put_ready), 1);

      putw(8'h5A, 8'h07);
      check("z_cursor", 32'(cursor), 1);
      w0 = we_cnt;
      put(8'h0C, 8'h2E);
      cyc = 0;
      while (we_cnt - w0 < 2000 && cyc < 5000) begin
         @(negedge clock);
         cyc++;
      end
      check("abort_reach", 32'(we_cnt - w0), 2000);
      reset_n = 1'b0;
      #1;
      check("abort_ready", 32'(put_ready), 1);
      check("abort_busy", 32'(busy), 0);
      check("abort_we", 32'(m_we), 0);
      check("abort_addr", 32'(m_address), 0);
      check("abort_wdata", 32'(m_wdata), 0);
      check("abort_cursor", 32'(cursor), 0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("abort_m1998", 32'(mem[1998]), 8'h20);
      check("abort_m1999", 32'(mem[1999]), 8'h2E);
      check("abort_m2001", 32'(mem[2001]), 8'h1F);

      put(8'h08, 8'h07);
      @(negedge clock);
      check("bs_rst_cursor", 32'(cursor), 0);
      for (int i = 0; i < 3; i++) putw(8'h61 + 8'(i), 8'h07);
      put(8'h08, 8'h07);
      @(negedge clock);
      check("bs3_cursor", 32'(cursor), 2);
      putw(8'h63, 8'h07);
      w0 = we_cnt;
      put(8'h09, 8'h07);
      wait_ready(cyc);
`ifdef TTY_TAB_EN
      check("tab_cyc", 32'(cyc), 0);
      check("tab_cursor", 32'(cursor), 8);
      for (int i = 0; i < 67; i++) putw(8'h40, 8'h07);
      check("cur75", 32'(cursor), 75);
      w0 = we_cnt;
      put(8'h09, 8'h07);
      @(negedge clock);
      check("tab_clamp", 32'(cursor), 79);
      put(8'h09, 8'h07);
      @(negedge clock);
      check("tab_at79", 32'(cursor), 79);
      check("tab_nowe", 32'(we_cnt - w0), 0);
`else
      check("tab_cyc", 32'(cyc), 2);
      check("tab_cursor", 32'(cursor), 4);
      check("tab_m6", 32'(mem[6]), 8'h09);
      check("tab_m7", 32'(mem[7]), 8'h07);
      check("tab_wecnt", 32'(we_cnt - w0), 2);
`endif

      putw(8'h0D, 8'h07);
      for (int i = 0; i < 24; i++) putw(8'h0A, 8'h07);
      check("lf_bottom", 32'(cursor), 1920);
      w0 = we_cnt;
      put(8'h0A, 8'h4C);
      wait_ready(cyc);
      check("lfs_busy", 32'(cyc), 7840);
      check("lfs_cursor", 32'(cursor), 1920);
      check("lfs_wecnt", 32'(we_cnt - w0), 4000);
      check("lfs_m3840", 32'(mem[3840]), 8'h20);
      check("lfs_m3841", 32'(mem[3841]), 8'h4C);
      check("bad_addr", 32'(bad_addr), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
